// File: rtl/axi4_sram_arbiter_2x1.sv
// Two-master to one-slave AXI4 arbiter with independent read and write paths.
// Optional round-robin tie-break: define AXI4_SRAM_ARBITER_2X1_RR_EN (default is fixed priority, m0 wins).
module axi4_sram_arbiter_2x1 #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  // requester 0
  input  logic                          m0_awvalid_i,
  output logic                          m0_awready_o,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  m0_awaddr_i,
  input  logic [AXI_ID_WIDTH-1:0]       m0_awid_i,
  input  logic [7:0]                    m0_awlen_i,
  input  logic [2:0]                    m0_awsize_i,
  input  logic [1:0]                    m0_awburst_i,
  input  logic                          m0_wvalid_i,
  output logic                          m0_wready_o,
  input  logic [AXI_DATA_WIDTH-1:0]     m0_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   m0_wstrb_i,
  input  logic                          m0_wlast_i,
  output logic                          m0_bvalid_o,
  input  logic                          m0_bready_i,
  output logic [AXI_ID_WIDTH-1:0]       m0_bid_o,
  output logic [1:0]                    m0_bresp_o,
  input  logic                          m0_arvalid_i,
  output logic                          m0_arready_o,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  m0_araddr_i,
  input  logic [AXI_ID_WIDTH-1:0]       m0_arid_i,
  input  logic [7:0]                    m0_arlen_i,
  input  logic [2:0]                    m0_arsize_i,
  input  logic [1:0]                    m0_arburst_i,
  output logic                          m0_rvalid_o,
  input  logic                          m0_rready_i,
  output logic [AXI_DATA_WIDTH-1:0]     m0_rdata_o,
  output logic [AXI_ID_WIDTH-1:0]       m0_rid_o,
  output logic [1:0]                    m0_rresp_o,
  output logic                          m0_rlast_o,
  // requester 1
  input  logic                          m1_awvalid_i,
  output logic                          m1_awready_o,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  m1_awaddr_i,
  input  logic [AXI_ID_WIDTH-1:0]       m1_awid_i,
  input  logic [7:0]                    m1_awlen_i,
  input  logic [2:0]                    m1_awsize_i,
  input  logic [1:0]                    m1_awburst_i,
  input  logic                          m1_wvalid_i,
  output logic                          m1_wready_o,
  input  logic [AXI_DATA_WIDTH-1:0]     m1_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   m1_wstrb_i,
  input  logic                          m1_wlast_i,
  output logic                          m1_bvalid_o,
  input  logic                          m1_bready_i,
  output logic [AXI_ID_WIDTH-1:0]       m1_bid_o,
  output logic [1:0]                    m1_bresp_o,
  input  logic                          m1_arvalid_i,
  output logic                          m1_arready_o,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  m1_araddr_i,
  input  logic [AXI_ID_WIDTH-1:0]       m1_arid_i,
  input  logic [7:0]                    m1_arlen_i,
  input  logic [2:0]                    m1_arsize_i,
  input  logic [1:0]                    m1_arburst_i,
  output logic                          m1_rvalid_o,
  input  logic                          m1_rready_i,
  output logic [AXI_DATA_WIDTH-1:0]     m1_rdata_o,
  output logic [AXI_ID_WIDTH-1:0]       m1_rid_o,
  output logic [1:0]                    m1_rresp_o,
  output logic                          m1_rlast_o,
  // shared downstream slave
  output logic                          s_awvalid_o,
  input  logic                          s_awready_i,
  output logic [AXI_ADDRESS_WIDTH-1:0]  s_awaddr_o,
  output logic [AXI_ID_WIDTH-1:0]       s_awid_o,
  output logic [7:0]                    s_awlen_o,
  output logic [2:0]                    s_awsize_o,
  output logic [1:0]                    s_awburst_o,
  output logic                          s_wvalid_o,
  input  logic                          s_wready_i,
  output logic [AXI_DATA_WIDTH-1:0]     s_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   s_wstrb_o,
  output logic                          s_wlast_o,
  input  logic                          s_bvalid_i,
  output logic                          s_bready_o,
  input  logic [AXI_ID_WIDTH-1:0]       s_bid_i,
  input  logic [1:0]                    s_bresp_i,
  output logic                          s_arvalid_o,
  input  logic                          s_arready_i,
  output logic [AXI_ADDRESS_WIDTH-1:0]  s_araddr_o,
  output logic [AXI_ID_WIDTH-1:0]       s_arid_o,
  output logic [7:0]                    s_arlen_o,
  output logic [2:0]                    s_arsize_o,
  output logic [1:0]                    s_arburst_o,
  input  logic                          s_rvalid_i,
  output logic                          s_rready_o,
  input  logic [AXI_DATA_WIDTH-1:0]     s_rdata_i,
  input  logic [AXI_ID_WIDTH-1:0]       s_rid_i,
  input  logic [1:0]                    s_rresp_i,
  input  logic                          s_rlast_i
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

  wstate_e w_state_q;
  rstate_e r_state_q;
  logic    wgrant_q, rgrant_q;
  logic    wgrant_d, rgrant_d;
  logic    w_addr, w_data, w_resp, r_addr, r_data;

`ifdef AXI4_SRAM_ARBITER_2X1_RR_EN
  logic w_lastgnt_q, r_lastgnt_q;
  // On a tie the master that did not win last time on this path gets the grant.
  assign wgrant_d = (m0_awvalid_i && m1_awvalid_i) ? ~w_lastgnt_q : ~m0_awvalid_i;
  assign rgrant_d = (m0_arvalid_i && m1_arvalid_i) ? ~r_lastgnt_q : ~m0_arvalid_i;
`else
  assign wgrant_d = ~m0_awvalid_i;
  assign rgrant_d = ~m0_arvalid_i;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q   <= W_IDLE;
      wgrant_q    <= 1'b0;
`ifdef AXI4_SRAM_ARBITER_2X1_RR_EN
      w_lastgnt_q <= 1'b1;
`endif
    end else begin
      case (w_state_q)
        W_IDLE: if (m0_awvalid_i || m1_awvalid_i) begin
          wgrant_q    <= wgrant_d;
`ifdef AXI4_SRAM_ARBITER_2X1_RR_EN
          w_lastgnt_q <= wgrant_d;
`endif
          w_state_q   <= W_ADDR;
        end
        W_ADDR: if (s_awready_i) w_state_q <= W_DATA;
        W_DATA: if (s_wvalid_o && s_wready_i && s_wlast_o) w_state_q <= W_RESP;
        W_RESP: if (s_bvalid_i && s_bready_o) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q   <= R_IDLE;
      rgrant_q    <= 1'b0;
`ifdef AXI4_SRAM_ARBITER_2X1_RR_EN
      r_lastgnt_q <= 1'b1;
`endif
    end else begin
      case (r_state_q)
        R_IDLE: if (m0_arvalid_i || m1_arvalid_i) begin
          rgrant_q    <= rgrant_d;
`ifdef AXI4_SRAM_ARBITER_2X1_RR_EN
          r_lastgnt_q <= rgrant_d;
`endif
          r_state_q   <= R_ADDR;
        end
        R_ADDR: if (s_arready_i) r_state_q <= R_DATA;
        R_DATA: if (s_rvalid_i && s_rready_o && s_rlast_i) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign w_addr = (w_state_q == W_ADDR);
  assign w_data = (w_state_q == W_DATA);
  assign w_resp = (w_state_q == W_RESP);
  assign r_addr = (r_state_q == R_ADDR);
  assign r_data = (r_state_q == R_DATA);

  // Write path: handshakes gated by state and grant, payload muxed by grant.
  assign s_awvalid_o  = w_addr;
  assign s_awaddr_o   = wgrant_q ? m1_awaddr_i  : m0_awaddr_i;
  assign s_awid_o     = wgrant_q ? m1_awid_i    : m0_awid_i;
  assign s_awlen_o    = wgrant_q ? m1_awlen_i   : m0_awlen_i;
  assign s_awsize_o   = wgrant_q ? m1_awsize_i  : m0_awsize_i;
  assign s_awburst_o  = wgrant_q ? m1_awburst_i : m0_awburst_i;
  assign m0_awready_o = w_addr && !wgrant_q && s_awready_i;
  assign m1_awready_o = w_addr &&  wgrant_q && s_awready_i;

  assign s_wvalid_o   = w_data && (wgrant_q ? m1_wvalid_i : m0_wvalid_i);
  assign s_wdata_o    = wgrant_q ? m1_wdata_i : m0_wdata_i;
  assign s_wstrb_o    = wgrant_q ? m1_wstrb_i : m0_wstrb_i;
  assign s_wlast_o    = wgrant_q ? m1_wlast_i : m0_wlast_i;
  assign m0_wready_o  = w_data && !wgrant_q && s_wready_i;
  assign m1_wready_o  = w_data &&  wgrant_q && s_wready_i;

  assign s_bready_o   = w_resp && (wgrant_q ? m1_bready_i : m0_bready_i);
  assign m0_bvalid_o  = w_resp && !wgrant_q && s_bvalid_i;
  assign m1_bvalid_o  = w_resp &&  wgrant_q && s_bvalid_i;
  assign m0_bid_o     = s_bid_i;
  assign m1_bid_o     = s_bid_i;
  assign m0_bresp_o   = s_bresp_i;
  assign m1_bresp_o   = s_bresp_i;

  // Read path mirrors the write path.
  assign s_arvalid_o  = r_addr;
  assign s_araddr_o   = rgrant_q ? m1_araddr_i  : m0_araddr_i;
  assign s_arid_o     = rgrant_q ? m1_arid_i    : m0_arid_i;
  assign s_arlen_o    = rgrant_q ? m1_arlen_i   : m0_arlen_i;
  assign s_arsize_o   = rgrant_q ? m1_arsize_i  : m0_arsize_i;
  assign s_arburst_o  = rgrant_q ? m1_arburst_i : m0_arburst_i;
  assign m0_arready_o = r_addr && !rgrant_q && s_arready_i;
  assign m1_arready_o = r_addr &&  rgrant_q && s_arready_i;

  assign s_rready_o   = r_data && (rgrant_q ? m1_rready_i : m0_rready_i);
  assign m0_rvalid_o  = r_data && !rgrant_q && s_rvalid_i;
  assign m1_rvalid_o  = r_data &&  rgrant_q && s_rvalid_i;
  assign m0_rdata_o   = s_rdata_i;
  assign m1_rdata_o   = s_rdata_i;
  assign m0_rid_o     = s_rid_i;
  assign m1_rid_o     = s_rid_i;
  assign m0_rresp_o   = s_rresp_i;
  assign m1_rresp_o   = s_rresp_i;
  assign m0_rlast_o   = s_rlast_i;
  assign m1_rlast_o   = s_rlast_i;

endmodule
